spi_flash_read_phy: RTL and testbench

// SPI-mode-0 serial engine below the TileLink SPI flash front end. Takes one read request
// (24-bit byte address, TileLink log2 size) per tx pulse and issues a standard READ (0x03) to
// the flash. Returns 2^size bytes as 32-bit little-endian words, one enqueue pulse per word,

---
 rtl/spi_flash_read_phy_if.sv | 29 ++
 rtl/spi_flash_read_phy.sv | 210 +++++++++++++++++++++
 tb/tb_spi_flash_read_phy.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_read_phy_if.sv
// Request/response bus between the SPI flash front end and the serial read engine.
// The front end (master) issues one read per tx_i pulse and collects 32-bit words
// from the engine (slave) on each enqueue_o pulse.
interface spi_flash_read_phy_if;
    logic        tx_i;
    logic [23:0] address_i;
    logic [3:0]  size_i;
    logic        busy_o;
    logic        enqueue_o;
    logic [31:0] data_o;

    modport master (
        output tx_i,
        output address_i,
        output size_i,
        input  busy_o,
        input  enqueue_o,
        input  data_o
    );

    modport slave (
        input  tx_i,
        input  address_i,
        input  size_i,
        output busy_o,
        output enqueue_o,
        output data_o
    );
endinterface

// File: rtl/spi_flash_read_phy.sv
// SPI mode-0 read engine: sends READ (0x03) plus a 24-bit address, then shifts in
// 2^size bytes and hands them out as little-endian 32-bit words, one enqueue pulse
// per word. All pin outputs are registered from the next-state decode so they line
// up exactly with the state register and never glitch.
module spi_flash_read_phy #(
    parameter int SCK_HALF = 2,
    parameter int CS_DESEL = 4,
    parameter int MAX_SIZE = 9
) (
    input  logic                       flash_clock_i,
    input  logic                       flash_reset_i,
    spi_flash_read_phy_if.slave        bus,
    output logic                       flash_cs_n,
    output logic                       flash_mosi,
    input  logic                       flash_miso,
    output logic                       flash_sck
);

    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(CS_DESEL - 1);
    localparam logic [3:0]       SIZE_CAP   = 4'(MAX_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DESEL
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [12:0]        bit_q, bit_d;

    logic [31:0]        cmd_q;
    logic [12:0]        last_bit_q;
    logic [9:0]         last_byte_q;
    logic [9:0]         byte_q;
    logic [2:0]         bit_in_byte_q;
    logic [6:0]         byte_sr_q;
    logic [31:0]        word_q;

    logic               busy_q;
    logic               enqueue_q;
    logic [31:0]        data_q;
    logic               cs_n_q;
    logic               sck_q;
    logic               mosi_q;

    logic               accept;
    logic [3:0]         eff_size;
    logic [9:0]         num_bytes;
    logic [12:0]        last_bit;
    logic               sample;
    logic               byte_done;
    logic               enq_d;
    logic [7:0]         new_byte;
    logic [31:0]        word_with_byte;
    logic               sck_d;
    logic               cs_n_d;
    logic               mosi_d;
    logic               busy_d;

    assign bus.busy_o    = busy_q;
    assign bus.enqueue_o = enqueue_q;
    assign bus.data_o    = data_q;
    assign flash_cs_n    = cs_n_q;
    assign flash_sck     = sck_q;
    assign flash_mosi    = mosi_q;

    // Request decode: clamp the size, then derive the final bit and byte indices.
    always_comb begin
        accept         = (state_q == ST_IDLE) && bus.tx_i;
        eff_size       = (bus.size_i > SIZE_CAP) ? SIZE_CAP : bus.size_i;
        num_bytes      = 10'd1 << eff_size;
        last_bit       = 13'd31 + {num_bytes, 3'b000};
        sample         = (state_q == ST_SHIFT) && phase_q && (cnt_q == '0) && (bit_q >= 13'd32);
        byte_done      = sample && (bit_in_byte_q == 3'd7);
        enq_d          = byte_done && ((byte_q[1:0] == 2'd3) || (byte_q == last_byte_q));
        new_byte       = {byte_sr_q, flash_miso};
        word_with_byte = word_q | ({24'd0, new_byte} << {byte_q[1:0], 3'b000});
    end

    // Next-state logic: walks SETUP, the bit-by-bit SHIFT phases, HOLD and DESEL.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == last_bit_q) begin
                        state_d = ST_HOLD;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 13'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_DESEL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DESEL: begin
                if (cnt_q == DESEL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values for the coming cycle, decoded from the next state.
    always_comb begin
        sck_d  = (state_d == ST_SHIFT) && phase_d;
        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        busy_d = (state_d != ST_IDLE);
        mosi_d = 1'b0;
        if ((state_d == ST_SHIFT) && (bit_d < 13'd32)) begin
            mosi_d = cmd_q[~bit_d[4:0]];
        end
    end

    // State, datapath and registered outputs; reset aborts any transfer in one cycle.
    always_ff @(posedge flash_clock_i) begin
        if (flash_reset_i) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            bit_q         <= '0;
            cmd_q         <= '0;
            last_bit_q    <= '0;
            last_byte_q   <= '0;
            byte_q        <= '0;
            bit_in_byte_q <= '0;
            byte_sr_q     <= '0;
            word_q        <= '0;
            busy_q        <= 1'b0;
            enqueue_q     <= 1'b0;
            data_q        <= '0;
            cs_n_q        <= 1'b1;
            sck_q         <= 1'b0;
            mosi_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            enqueue_q <= enq_d;
            if (accept) begin
                cmd_q         <= {8'h03, bus.address_i};
                last_bit_q    <= last_bit;
                last_byte_q   <= num_bytes - 10'd1;
                byte_q        <= '0;
                bit_in_byte_q <= '0;
                word_q        <= '0;
            end else if (sample) begin
                byte_sr_q     <= new_byte[6:0];
                bit_in_byte_q <= bit_in_byte_q + 3'd1;
                if (byte_done) begin
                    byte_q <= byte_q + 10'd1;
                    word_q <= enq_d ? 32'd0 : word_with_byte;
                end
            end
            if (enq_d) begin
                data_q <= word_with_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_read_phy.sv
// Directed bench for spi_flash_read_phy (SCK_HALF=2, CS_DESEL=4, MAX_SIZE=9) with a
// byte-stream flash model on MISO and monitors for enqueues, busy runs and SCK edges.
module tb_spi_flash_read_phy;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_flash_read_phy_if bus();
    logic cs_n, mosi, sck;
    logic miso = 1'b0;

    spi_flash_read_phy #(.SCK_HALF(2), .CS_DESEL(4), .MAX_SIZE(9)) dut (
        .flash_clock_i (clk),
        .flash_reset_i (rst),
        .bus           (bus),
        .flash_cs_n    (cs_n),
        .flash_mosi    (mosi),
        .flash_miso    (miso),
        .flash_sck     (sck)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  flash_mem [0:511];
    int          rise_cnt  = 0;
    int          sck_total = 0;
    logic [31:0] mosi_cap  = '0;

    logic [31:0] enq_data [0:511];
    int          enq_cyc  [0:511];
    int          enq_n = 0;
    int          cyc   = 0;

    int   busy_runs  [0:63];
    int   desel_runs [0:63];
    int   gap_before [0:63];
    int   busy_n    = 0;
    int   run       = 0;
    int   desel_run = 0;
    int   low_run   = 0;
    logic busy_prev = 1'b0;

    // Cycle counter used to timestamp enqueues.
    always @(posedge clk) cyc <= cyc + 1;

    // SCK rising-edge bookkeeping: bit index, total edges and captured command/address.
    always @(posedge sck or negedge cs_n) begin
        if (sck) begin
            if (rise_cnt < 32) mosi_cap <= {mosi_cap[30:0], mosi};
            rise_cnt  <= rise_cnt + 1;
            sck_total <= sck_total + 1;
        end else begin
            rise_cnt <= 0;
        end
    end

    // Flash model: presents the next data bit, MSB first, after each SCK falling edge.
    always @(negedge sck) begin
        int d;
        d = rise_cnt - 32;
        if (d >= 0 && d < 4096) miso <= flash_mem[d >> 3][7 - (d & 7)];
        else                    miso <= 1'b0;
    end

    // Output monitor: records enqueued words and the length of each busy run.
    always @(negedge clk) begin
        if (bus.enqueue_o && enq_n < 512) begin
            enq_data[enq_n] = bus.data_o;
            enq_cyc[enq_n]  = cyc;
            enq_n++;
        end
        if (bus.busy_o) begin
            if (!busy_prev && busy_n < 64) gap_before[busy_n] = low_run;
            run++;
            if (cs_n) desel_run++;
            low_run = 0;
        end else begin
            if (busy_prev && busy_n < 64) begin
                busy_runs[busy_n]  = run;
                desel_runs[busy_n] = desel_run;
                busy_n++;
            end
            run       = 0;
            desel_run = 0;
            low_run++;
        end
        busy_prev = bus.busy_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] addr, input logic [3:0] size);
        @(negedge clk);
        bus.tx_i      = 1'b1;
        bus.address_i = addr;
        bus.size_i    = size;
        @(negedge clk);
        bus.tx_i      = 1'b0;
    endtask

    task automatic waitRuns(input int target, input int limit, input string tag);
        int n = 0;
        while (busy_n < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(busy_n >= target), 32'd1);
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b, e, s, n;
        logic [31:0] exp_word;

        bus.tx_i      = 1'b0;
        bus.address_i = '0;
        bus.size_i    = '0;
        for (int k = 0; k < 512; k++) flash_mem[k] = 8'h00;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n",    32'(cs_n),          32'd1);
        checkOutput("rst_sck",     32'(sck),           32'd0);
        checkOutput("rst_mosi",    32'(mosi),          32'd0);
        checkOutput("rst_busy",    32'(bus.busy_o),    32'd0);
        checkOutput("rst_enqueue", 32'(bus.enqueue_o), 32'd0);
        checkOutput("rst_data",    bus.data_o,         32'd0);
        rst = 1'b0;
        $display("[TB] reset checks done");

        // Four-byte read at 0x000100.
        flash_mem[0] = 8'h11; flash_mem[1] = 8'h22; flash_mem[2] = 8'h33; flash_mem[3] = 8'h44;
        b = busy_n; e = enq_n;
        applyStimulus(24'h000100, 4'd2);
        checkOutput("t1_busy_t0p1", 32'(bus.busy_o), 32'd1);
        checkOutput("t1_csn_t0p1",  32'(cs_n),       32'd0);
        waitRuns(b + 1, 2000, "t1_done");
        checkOutput("t1_mosi",      mosi_cap,        32'h03000100);
        checkOutput("t1_enq_count", 32'(enq_n - e),  32'd1);
        checkOutput("t1_data",      enq_data[e],     32'h44332211);
        checkOutput("t1_busy_len",  32'(busy_runs[b]), 32'd264);
        checkOutput("t1_desel_len", 32'(desel_runs[b]), 32'd4);

        // Single byte read at 0x0000FF.
        flash_mem[0] = 8'hA5;
        b = busy_n; e = enq_n; s = sck_total;
        applyStimulus(24'h0000FF, 4'd0);
        waitRuns(b + 1, 2000, "t2_done");
        checkOutput("t2_mosi",      mosi_cap,            32'h030000FF);
        checkOutput("t2_enq_count", 32'(enq_n - e),      32'd1);
        checkOutput("t2_data",      enq_data[e],         32'h000000A5);
        checkOutput("t2_sck_rises", 32'(sck_total - s),  32'd40);
        checkOutput("t2_busy_len",  32'(busy_runs[b]),   32'd168);

        // 64-byte read of incrementing data; one word every 32 bits * 4 cycles.
        for (int k = 0; k < 64; k++) flash_mem[k] = 8'(k);
        b = busy_n; e = enq_n;
        applyStimulus(24'h123456, 4'd6);
        waitRuns(b + 1, 4000, "t3_done");
        checkOutput("t3_mosi",       mosi_cap,                      32'h03123456);
        checkOutput("t3_enq_count",  32'(enq_n - e),                32'd16);
        checkOutput("t3_first",      enq_data[e],                   32'h03020100);
        checkOutput("t3_last",       enq_data[e + 15],              32'h3F3E3D3C);
        checkOutput("t3_spacing",    32'(enq_cyc[e + 1] - enq_cyc[e]),  32'd128);
        checkOutput("t3_span",       32'(enq_cyc[e + 15] - enq_cyc[e]), 32'd1920);
        checkOutput("t3_busy_len",   32'(busy_runs[b]),             32'd2184);

        // tx held high: the second request is taken the cycle busy falls.
        flash_mem[0] = 8'h5C;
        b = busy_n; e = enq_n;
        @(negedge clk);
        bus.tx_i      = 1'b1;
        bus.address_i = 24'h000010;
        bus.size_i    = 4'd0;
        n = 0;
        while (!(busy_n == b + 1 && bus.busy_o) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        bus.tx_i = 1'b0;
        checkOutput("t4_second_start", 32'(busy_n == b + 1 && bus.busy_o), 32'd1);
        waitRuns(b + 2, 1000, "t4_done");
        repeat (20) @(negedge clk);
        #1;
        checkOutput("t4_run_count",  32'(busy_n - b),        32'd2);
        checkOutput("t4_gap",        32'(gap_before[b + 1]), 32'd1);
        checkOutput("t4_desel_len",  32'(desel_runs[b]),     32'd4);
        checkOutput("t4_busy_len2",  32'(busy_runs[b + 1]),  32'd168);
        checkOutput("t4_enq_count",  32'(enq_n - e),         32'd2);
        checkOutput("t4_data2",      enq_data[e + 1],        32'h0000005C);

        // Reset after two data bytes: immediate abort, no enqueue, then a clean rerun.
        flash_mem[0] = 8'h11; flash_mem[1] = 8'h22; flash_mem[2] = 8'h33; flash_mem[3] = 8'h44;
        e = enq_n;
        applyStimulus(24'h000100, 4'd2);
        n = 0;
        while (rise_cnt < 50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_reached_data", 32'(rise_cnt >= 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_cs_n",  32'(cs_n),       32'd1);
        checkOutput("t5_sck",   32'(sck),        32'd0);
        checkOutput("t5_busy",  32'(bus.busy_o), 32'd0);
        checkOutput("t5_data",  bus.data_o,      32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        checkOutput("t5_no_enq", 32'(enq_n - e), 32'd0);
        b = busy_n; e = enq_n;
        applyStimulus(24'h000100, 4'd2);
        waitRuns(b + 1, 2000, "t5_rerun_done");
        checkOutput("t5_rerun_data",     enq_data[e],     32'h44332211);
        checkOutput("t5_rerun_busy_len", 32'(busy_runs[b]), 32'd264);

        // Oversized request is clamped to 512 bytes.
        for (int k = 0; k < 512; k++) flash_mem[k] = 8'(k * 7 + 3);
        b = busy_n; e = enq_n; s = sck_total;
        applyStimulus(24'hABCDEF, 4'd12);
        waitRuns(b + 1, 20000, "t6_done");
        checkOutput("t6_enq_count", 32'(enq_n - e),     32'd128);
        checkOutput("t6_sck_rises", 32'(sck_total - s), 32'd4128);
        checkOutput("t6_busy_len",  32'(busy_runs[b]),  32'd16520);
        for (int j = 0; j < 128; j++) begin
            exp_word = {flash_mem[4*j + 3], flash_mem[4*j + 2], flash_mem[4*j + 1], flash_mem[4*j]};
            checkOutput($sformatf("t6_word%0d", j), enq_data[e + j], exp_word);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
